// File: rtl/mask_scatter_unpacker_pkg.sv
// Shared constants and FSM encoding for the mask-driven scatter unpacker.
package mask_scatter_unpacker_pkg;

    localparam int NUM_ELEM  = 128;
    localparam int ELEM_W    = 8;
    localparam int BEAT_ELEM = 16;
    localparam int CNT_W     = 8;
    localparam int NUM_BEATS = NUM_ELEM / BEAT_ELEM;
    localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
    localparam int IDX_W     = $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

endpackage

// File: rtl/mask_scatter_unpacker_excl_prefix_count.sv
// Exclusive prefix popcount: xpfx[i] = number of set bits below position i, plus the full total.
module excl_prefix_count
    import mask_scatter_unpacker_pkg::*;
(
    input  logic [NUM_ELEM-1:0]            mask_i,
    output logic [NUM_ELEM-1:0][CNT_W-1:0] xpfx_o,
    output logic [CNT_W-1:0]               total_o
);

    always_comb begin
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            xpfx_o[i] = acc;
            acc       = acc + CNT_W'(mask_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/mask_scatter_unpacker.sv
// Rebuilds a dense vector from an occupancy mask and a compacted element stream.
//   state  | meaning
//   IDLE   | waiting for a mask
//   FILL   | collecting packed beats into the element buffer
//   EXPAND | one-cycle scatter of buffered elements to their mask positions
//   OUT    | holding the dense vector until the consumer takes it
module mask_scatter_unpacker
    import mask_scatter_unpacker_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mask_valid,
    output logic                          mask_ready,
    input  logic [NUM_ELEM-1:0]           mask,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BEAT_ELEM*ELEM_W-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]    out_data,
    output logic [CNT_W-1:0]              out_count
);

    state_e                             state_q, state_d;
    logic [NUM_ELEM-1:0]                mask_q;
    logic [BEAT_W-1:0]                  beat_cnt_q;
    logic [CNT_W-1:0]                   fill_cnt_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]    buf_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]    out_data_q;
    logic [CNT_W-1:0]                   out_count_q;

    logic [NUM_ELEM-1:0][CNT_W-1:0]     xpfx;
    logic [CNT_W-1:0]                   pop;
    logic                               fill_done;

    excl_prefix_count u_pfx (
        .mask_i  (mask_q),
        .xpfx_o  (xpfx),
        .total_o (pop)
    );

    // One extra bit so the compare stays exact even when pop == NUM_ELEM.
    assign fill_done = ({1'b0, fill_cnt_q} + (CNT_W+1)'(BEAT_ELEM)) >= {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        mask_ready = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mask_ready = 1'b1;
                if (mask_valid) state_d = (mask == '0) ? ST_EXPAND : ST_FILL;
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid && fill_done) state_d = ST_EXPAND;
            end
            ST_EXPAND: state_d = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            beat_cnt_q  <= '0;
            fill_cnt_q  <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && mask_valid) begin
                mask_q     <= mask;
                beat_cnt_q <= '0;
                fill_cnt_q <= '0;
            end
            if (state_q == ST_FILL && in_valid) begin
                for (int b = 0; b < NUM_BEATS; b++) begin
                    if (beat_cnt_q == BEAT_W'(b)) buf_q[b*BEAT_ELEM +: BEAT_ELEM] <= in_data;
                end
                beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                fill_cnt_q <= fill_cnt_q + CNT_W'(BEAT_ELEM);
            end
            // Set mask bits always have xpfx < NUM_ELEM, so the upper-bit test only guards the index range.
            if (state_q == ST_EXPAND) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    out_data_q[i] <= (mask_q[i] && (xpfx[i][CNT_W-1:IDX_W] == '0))
                                     ? buf_q[xpfx[i][IDX_W-1:0]] : '0;
                end
                out_count_q <= pop;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_mask_scatter_unpacker.sv
// Directed self-checking bench for mask_scatter_unpacker.
module tb_mask_scatter_unpacker;
    import mask_scatter_unpacker_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        mask_valid;
    logic                        mask_ready;
    logic [NUM_ELEM-1:0]         mask;
    logic                        in_valid;
    logic                        in_ready;
    logic [BEAT_ELEM*ELEM_W-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_ELEM*ELEM_W-1:0]  out_data;
    logic [CNT_W-1:0]            out_count;

    int n_cmp = 0;
    int n_err = 0;
    int beats_total = 0;

    always #5 clk = ~clk;

    mask_scatter_unpacker dut (
        .clk        (clk),
        .reset      (reset),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask       (mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count)
    );

    always @(posedge clk) if (in_valid && in_ready) beats_total <= beats_total + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [NUM_ELEM*ELEM_W-1:0] obs,
                           input logic [NUM_ELEM*ELEM_W-1:0] exp);
        int pos;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            pos = 0;
            for (int i = NUM_ELEM - 1; i >= 0; i--)
                if (obs[i*ELEM_W +: ELEM_W] !== exp[i*ELEM_W +: ELEM_W]) pos = i;
            $error("FAIL %s: position %0d observed %02h expected %02h", tag, pos,
                   obs[pos*ELEM_W +: ELEM_W], exp[pos*ELEM_W +: ELEM_W]);
        end
    endtask

    task automatic send_mask(input logic [NUM_ELEM-1:0] m, input string tag);
        int t;
        @(negedge clk);
        mask = m;
        mask_valid = 1'b1;
        t = 0;
        while (!mask_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_mask_hs"}, 32'(t < 50), 32'd1);
        @(negedge clk);
        mask_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [BEAT_ELEM*ELEM_W-1:0] d, input string tag);
        int t;
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_beat_hs"}, 32'(t < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_out_wait"}, 32'(t < 50), 32'd1);
    endtask

    task automatic take_out(input string tag);
        out_ready = 1'b1;
        chk({tag, "_mask_ready_in_out"}, 32'(mask_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_after_take"}, 32'(out_valid), 32'd0);
        chk({tag, "_mask_ready_after_take"}, 32'(mask_ready), 32'd1);
    endtask

    // mask 0x13 (bits 0,1,4) with one beat carrying 01,02,03 in slots 0..2
    task automatic run_sc1(input string tag, input logic [NUM_ELEM*ELEM_W-1:0] exp1);
        logic [BEAT_ELEM*ELEM_W-1:0] d;
        int b0;
        b0 = beats_total;
        d = {BEAT_ELEM{8'hAA}};
        d[0 +: 8] = 8'h01;
        d[8 +: 8] = 8'h02;
        d[16 +: 8] = 8'h03;
        send_mask(128'h13, tag);
        send_beat(d, tag);
        in_valid = 1'b1;
        chk({tag, "_in_ready_after_beat"}, 32'(in_ready), 32'd0);
        chk({tag, "_latency_cycle1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_latency_cycle2"}, 32'(out_valid), 32'd1);
        chk_vec({tag, "_data"}, out_data, exp1);
        chk({tag, "_count"}, 32'(out_count), 32'd3);
        take_out(tag);
        in_valid = 1'b0;
        chk({tag, "_beats"}, 32'(beats_total - b0), 32'd1);
    endtask

    initial begin
        logic [NUM_ELEM*ELEM_W-1:0]  exp1, expv;
        logic [NUM_ELEM-1:0]         m4;
        logic [BEAT_ELEM*ELEM_W-1:0] d;
        int b0, j;

        reset = 1'b1;
        mask_valid = 1'b0;
        mask = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        exp1 = '0;
        exp1[0*8 +: 8] = 8'h01;
        exp1[1*8 +: 8] = 8'h02;
        exp1[4*8 +: 8] = 8'h03;

        repeat (3) @(negedge clk);
        chk("rst_mask_ready", 32'(mask_ready), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_vec("rst_out_data", out_data, '0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        reset = 1'b0;

        run_sc1("s1", exp1);

        // empty mask: no beat accepted even with in_valid held high
        b0 = beats_total;
        in_valid = 1'b1;
        send_mask('0, "s2");
        chk("s2_in_ready", 32'(in_ready), 32'd0);
        chk("s2_latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("s2_latency_cycle2", 32'(out_valid), 32'd1);
        chk_vec("s2_data", out_data, '0);
        chk("s2_count", 32'(out_count), 32'd0);
        take_out("s2");
        in_valid = 1'b0;
        chk("s2_beats", 32'(beats_total - b0), 32'd0);

        // all-ones mask, 8 beats with element j = j
        b0 = beats_total;
        send_mask({NUM_ELEM{1'b1}}, "s3");
        for (int bt = 0; bt < NUM_BEATS; bt++) begin
            for (int k = 0; k < BEAT_ELEM; k++) d[k*8 +: 8] = 8'(bt*BEAT_ELEM + k);
            send_beat(d, "s3");
        end
        chk("s3_in_ready_after_last", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("s3_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < NUM_ELEM; i++) expv[i*8 +: 8] = 8'(i);
        chk_vec("s3_data", out_data, expv);
        chk("s3_count", 32'(out_count), 32'h80);
        take_out("s3");
        chk("s3_beats", 32'(beats_total - b0), 32'd8);

        // sparse mask, pop 28: two beats, slots 12..15 of beat 2 unused
        m4 = {4{32'b00100001000100100100010100000000}};
        b0 = beats_total;
        send_mask(m4, "s4");
        for (int bt = 0; bt < 2; bt++) begin
            for (int k = 0; k < BEAT_ELEM; k++)
                d[k*8 +: 8] = (bt*BEAT_ELEM + k < 28) ? 8'(8'h40 + bt*BEAT_ELEM + k) : 8'hEE;
            send_beat(d, "s4");
        end
        chk("s4_in_ready_after_last", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("s4_out_valid", 32'(out_valid), 32'd1);
        expv = '0;
        j = 0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (m4[i]) begin
                expv[i*8 +: 8] = 8'(8'h40 + j);
                j++;
            end
        end
        chk_vec("s4_data", out_data, expv);
        chk("s4_count", 32'(out_count), 32'd28);
        take_out("s4");
        chk("s4_beats", 32'(beats_total - b0), 32'd2);

        // back-pressure: output held for 10 cycles
        send_mask(128'h13, "s5");
        d = {BEAT_ELEM{8'h55}};
        d[0 +: 8] = 8'h01;
        d[8 +: 8] = 8'h02;
        d[16 +: 8] = 8'h03;
        send_beat(d, "s5");
        wait_out("s5");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("s5_hold_valid", 32'(out_valid), 32'd1);
            chk_vec("s5_hold_data", out_data, exp1);
            chk("s5_hold_count", 32'(out_count), 32'd3);
            chk("s5_hold_mask_ready", 32'(mask_ready), 32'd0);
        end
        take_out("s5");

        // reset in the middle of a fill
        send_mask({NUM_ELEM{1'b1}}, "s6");
        for (int bt = 0; bt < 3; bt++) send_beat({BEAT_ELEM{8'h77}}, "s6");
        chk("s6_in_ready_mid", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("s6_rst_mask_ready", 32'(mask_ready), 32'd1);
        chk("s6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("s6_rst_out_valid", 32'(out_valid), 32'd0);
        chk_vec("s6_rst_out_data", out_data, '0);
        chk("s6_rst_out_count", 32'(out_count), 32'd0);
        reset = 1'b0;
        run_sc1("s6_after", exp1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
